// File: rtl/lms_coef_update_pkg.sv
// lms_coef_update_pkg: fpu op codes, FSM states and double-precision helpers shared by the echo canceller
package lms_coef_update_pkg;
    localparam logic [2:0] FPU_ADD = 3'b000;
    localparam logic [2:0] FPU_SUB = 3'b001;
    localparam logic [2:0] FPU_MUL = 3'b010;
    localparam logic [2:0] FPU_DIV = 3'b011;
    localparam logic [63:0] DBL_ONE = 64'h3FF0000000000000;
    localparam logic [63:0] DBL_QNAN = 64'h7FF8000000000000;
    typedef enum logic [2:0] {IDLE, MUL_G, TAP_MUL, TAP_ADD, COMMIT} state_t;
    // m: hidden bit at [55], 52 fraction bits, guard at [2], sticky in [1:0]
    function automatic logic [63:0] round_pack(input logic s, input logic signed [12:0] e, input logic [55:0] m, input logic [1:0] rm);
        logic inexact, up;
        logic [53:0] r;
        logic signed [12:0] ee;
        inexact = |m[2:0];
        up = (rm == 2'b00) ? m[2] & (m[3] | m[1] | m[0]) : (rm == 2'b10) ? !s && inexact : (rm == 2'b11) ? s && inexact : 1'b0;
        r = {1'b0, m[55:3]} + {53'b0, up};
        ee = r[53] ? e + 13'sd1 : e;
        if (ee >= 13'sd2047) return {s, 11'h7FF, 52'h0};
        if (ee <= 13'sd0) return {s, 63'h0};
        return {s, ee[10:0], r[53] ? r[52:1] : r[51:0]};
    endfunction
endpackage

// File: rtl/lms_coef_update_fpu.sv
// lms_coef_update_fpu: multi-cycle IEEE-754 double add/sub/mul; enable pulse in, ready pulse with out_fp two cycles later
// Denormal operands and results flush to zero; unsupported ops return a quiet NaN.
module lms_coef_update_fpu
    import lms_coef_update_pkg::*;
(
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  rmode,
    input  logic [2:0]  fpu_op,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic [63:0] out_fp,
    output logic        ready
);
    logic [63:0] a_q, b_q, res;
    logic [2:0] op_q;
    logic [1:0] rm_q;
    logic pend;

    function automatic logic is_zero(input logic [10:0] ex);
        return ex == 11'h0;
    endfunction
    function automatic logic is_inf(input logic [62:0] v);
        return v[62:52] == 11'h7FF && v[51:0] == 52'h0;
    endfunction
    function automatic logic is_nan(input logic [62:0] v);
        return v[62:52] == 11'h7FF && v[51:0] != 52'h0;
    endfunction

    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm);
        logic s;
        logic [105:0] prod;
        logic signed [12:0] e;
        s = a[63] ^ b[63];
        if (is_nan(a[62:0]) || is_nan(b[62:0]) || (is_inf(a[62:0]) && is_zero(b[62:52])) || (is_zero(a[62:52]) && is_inf(b[62:0]))) return DBL_QNAN;
        if (is_inf(a[62:0]) || is_inf(b[62:0])) return {s, 11'h7FF, 52'h0};
        if (is_zero(a[62:52]) || is_zero(b[62:52])) return {s, 63'h0};
        prod = {53'b0, 1'b1, a[51:0]} * {53'b0, 1'b1, b[51:0]};
        e = $signed({2'b0, a[62:52]}) + $signed({2'b0, b[62:52]}) - 13'sd1023;
        return prod[105] ? round_pack(s, e + 13'sd1, {prod[105:51], |prod[50:0]}, rm) : round_pack(s, e, {prod[104:50], |prod[49:0]}, rm);
    endfunction

    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm);
        logic [63:0] x, y;
        logic [10:0] d;
        logic [111:0] w;
        logic [56:0] sum;
        logic [5:0] lz;
        logic signed [12:0] e;
        if (is_nan(a[62:0]) || is_nan(b[62:0]) || (is_inf(a[62:0]) && is_inf(b[62:0]) && a[63] != b[63])) return DBL_QNAN;
        if (is_inf(a[62:0])) return a;
        if (is_inf(b[62:0]) || is_zero(a[62:52])) return is_zero(b[62:52]) ? {a[63] & b[63], 63'h0} : b;
        if (is_zero(b[62:52])) return a;
        x = (b[62:0] > a[62:0]) ? b : a;
        y = (b[62:0] > a[62:0]) ? a : b;
        d = x[62:52] - y[62:52];
        // smaller operand is aligned with guard/round bits and a sticky OR of everything shifted out
        w = {1'b1, y[51:0], 59'b0} >> ((d > 11'd63) ? 7'd63 : d[6:0]);
        sum = (x[63] ^ y[63]) ? {2'b01, x[51:0], 3'b0} - {1'b0, w[111:57], |w[56:0]} : {2'b01, x[51:0], 3'b0} + {1'b0, w[111:57], |w[56:0]};
        e = $signed({2'b0, x[62:52]});
        lz = '0;
        for (int i = 0; i < 56; i++) if (sum[i]) lz = 6'(55 - i);
        if (sum == '0) return {rm == 2'b11, 63'h0};
        if (sum[56]) return round_pack(x[63], e + 13'sd1, {sum[56:2], |sum[1:0]}, rm);
        return round_pack(x[63], e - $signed({7'b0, lz}), sum[55:0] << lz, rm);
    endfunction

    always_comb res = (op_q == FPU_MUL) ? fp_mul(a_q, b_q, rm_q) : (op_q == FPU_ADD) ? fp_add(a_q, b_q, rm_q) :
                      (op_q == FPU_SUB) ? fp_add(a_q, {~b_q[63], b_q[62:0]}, rm_q) : DBL_QNAN;

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            op_q <= FPU_ADD;
            rm_q <= 2'b00;
            pend <= 1'b0;
            ready <= 1'b0;
            out_fp <= '0;
        end else begin
            pend <= enable;
            ready <= pend;
            if (enable) begin
                a_q <= opa;
                b_q <= opb;
                op_q <= fpu_op;
                rm_q <= rmode;
            end
            if (pend) out_fp <= res;
        end
    end
endmodule

// File: rtl/lms_coef_update.sv
// lms_coef_update: LMS adaptation of 4 double coefficients, para_k += (mu*e)*lag_k, via one shared fpu
// Define LMS_COEF_CLAMP_EN to saturate committed coefficients to +/-1.0.
module lms_coef_update
    import lms_coef_update_pkg::*;
#(
    parameter logic [63:0] INIT_COEF = 64'h0,
    parameter logic [1:0]  FPU_RMODE = 2'b00
) (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic        error_valid,
    input  logic [63:0] error_in,
    input  logic [63:0] lag_0,
    input  logic [63:0] lag_1,
    input  logic [63:0] lag_2,
    input  logic [63:0] lag_3,
    input  logic [63:0] mu,
    output logic [63:0] para_0,
    output logic [63:0] para_1,
    output logic [63:0] para_2,
    output logic [63:0] para_3,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    state_t state;
    logic [1:0] tap;
    logic [63:0] e_q, mu_q, g_q, p_q;
    logic [3:0][63:0] lag_q, shadow, para;
    logic fpu_en, fpu_ready;
    logic [2:0] fpu_op;
    logic [63:0] fpu_opa, fpu_opb, fpu_out;

`ifdef LMS_COEF_CLAMP_EN
    function automatic logic [63:0] commit_val(input logic [63:0] v);
        return (v[62:52] > 11'h3FF || (v[62:52] == 11'h3FF && v[51:0] != 52'h0)) ? {v[63], DBL_ONE[62:0]} : v;
    endfunction
`else
    function automatic logic [63:0] commit_val(input logic [63:0] v);
        return v;
    endfunction
`endif

    always_comb begin
        fpu_op = (state == TAP_ADD) ? FPU_ADD : FPU_MUL;
        fpu_opa = (state == MUL_G) ? mu_q : (state == TAP_MUL) ? g_q : shadow[tap];
        fpu_opb = (state == MUL_G) ? e_q : (state == TAP_MUL) ? lag_q[tap] : p_q;
    end

    lms_coef_update_fpu u_fpu (
        .clk_operation(clk_operation),
        .rst(rst),
        .enable(fpu_en),
        .rmode(FPU_RMODE),
        .fpu_op(fpu_op),
        .opa(fpu_opa),
        .opb(fpu_opb),
        .out_fp(fpu_out),
        .ready(fpu_ready)
    );

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state <= IDLE;
            tap <= 2'd0;
            busy <= 1'b0;
            done <= 1'b0;
            overrun <= 1'b0;
            fpu_en <= 1'b0;
            shadow <= {4{INIT_COEF}};
            para <= {4{INIT_COEF}};
        end else begin
            fpu_en <= 1'b0;
            done <= 1'b0;
            if (error_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (error_valid && enable) begin
                    state <= MUL_G;
                    busy <= 1'b1;
                    fpu_en <= 1'b1;
                    tap <= 2'd0;
                    e_q <= error_in;
                    mu_q <= mu;
                    lag_q <= {lag_3, lag_2, lag_1, lag_0};
                    // start from the committed values so a clamped commit carries into the next update
                    shadow <= para;
                end
                MUL_G: if (fpu_ready) begin
                    g_q <= fpu_out;
                    state <= TAP_MUL;
                    fpu_en <= 1'b1;
                end
                TAP_MUL: if (fpu_ready) begin
                    p_q <= fpu_out;
                    state <= TAP_ADD;
                    fpu_en <= 1'b1;
                end
                TAP_ADD: if (fpu_ready) begin
                    shadow[tap] <= fpu_out;
                    tap <= tap + 2'd1;
                    state <= (tap == 2'd3) ? COMMIT : TAP_MUL;
                    fpu_en <= tap != 2'd3;
                    done <= tap == 2'd3;
                end
                COMMIT: begin
                    para <= {commit_val(shadow[3]), commit_val(shadow[2]), commit_val(shadow[1]), commit_val(shadow[0])};
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign para_0 = para[0];
    assign para_1 = para[1];
    assign para_2 = para[2];
    assign para_3 = para[3];
endmodule

// File: tb/tb_lms_coef_update.sv
// tb_lms_coef_update: scoreboard bench; a real-arithmetic LMS model queues expected coefficients per accepted update
module tb_lms_coef_update;
    import lms_coef_update_pkg::*;
    localparam logic [63:0] ONE = 64'h3FF0000000000000;
    localparam logic [63:0] HALF = 64'h3FE0000000000000;
    localparam logic [63:0] NEG2 = 64'hC000000000000000;
    localparam logic [63:0] NEG1 = 64'hBFF0000000000000;
`ifdef LMS_COEF_CLAMP_EN
    localparam logic [63:0] THIRD = 64'h3FF0000000000000;
`else
    localparam logic [63:0] THIRD = 64'h3FF8000000000000;
`endif
    logic clk = 1'b0, rst = 1'b1, enable = 1'b1, error_valid = 1'b0;
    logic [63:0] error_in = '0, mu = '0;
    logic [3:0][63:0] lag = '0;
    logic [3:0][63:0] para;
    logic busy, done, overrun;
    int n_checks = 0, n_fail = 0, n_done = 0;
    real coef [4];
    logic [3:0][63:0] exp_q [$];

    always #5 clk = ~clk;

    lms_coef_update #(.INIT_COEF(64'h0), .FPU_RMODE(2'b00)) dut (
        .clk_operation(clk), .rst(rst), .enable(enable), .error_valid(error_valid),
        .error_in(error_in), .lag_0(lag[0]), .lag_1(lag[1]), .lag_2(lag[2]), .lag_3(lag[3]), .mu(mu),
        .para_0(para[0]), .para_1(para[1]), .para_2(para[2]), .para_3(para[3]),
        .busy(busy), .done(done), .overrun(overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic [63:0] m, input logic [63:0] e, input logic [3:0][63:0] l);
        real g;
        logic [3:0][63:0] x;
        g = $bitstoreal(m) * $bitstoreal(e);
        for (int k = 0; k < 4; k++) begin
            coef[k] = coef[k] + g * $bitstoreal(l[k]);
`ifdef LMS_COEF_CLAMP_EN
            if (coef[k] > 1.0) coef[k] = 1.0;
            else if (coef[k] < -1.0) coef[k] = -1.0;
`endif
            x[k] = $realtobits(coef[k]);
        end
        exp_q.push_back(x);
    endtask

    // dyadic values keep every fpu step exact, so rounding cannot separate model and DUT
    function automatic logic [63:0] rval(input int maxn, input int den);
        real r;
        r = real'($urandom_range(1, maxn)) / real'(den);
        return $realtobits($urandom_range(0, 1) ? -r : r);
    endfunction

    task automatic issue(input logic [63:0] m, input logic [63:0] e, input logic [3:0][63:0] l, input bit en, input bit accept);
        mu = m;
        error_in = e;
        lag = l;
        enable = en;
        error_valid = 1'b1;
        if (accept) model_update(m, e, l);
        @(posedge clk);
        #1;
        error_valid = 1'b0;
        enable = 1'b1;
        mu = {$urandom, $urandom};
        error_in = {$urandom, $urandom};
        lag = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no done within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) coef[k] = 0.0;
    endtask

    task automatic check_para(input string name, input logic [3:0][63:0] exp);
        for (int k = 0; k < 4; k++) check($sformatf("%s_para_%0d", name, k), para[k], exp[k]);
    endtask

    always @(negedge clk) if (done) begin
        logic [3:0][63:0] x;
        n_done++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_done: got done, expected none");
        end else begin
            x = exp_q.pop_front();
            for (int k = 0; k < 4; k++) check($sformatf("sb_para_%0d", k), para[k], x[k]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][63:0] l;
        int base;
        bit en;
        for (int k = 0; k < 4; k++) coef[k] = 0.0;
        repeat (3) @(posedge clk);
        #1;
        check_para("reset", {4{64'h0}});
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = n_done;
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        check("busy_in_flight", 64'(busy), 64'd1);
        wait_done("upd1");
        check_para("upd1", {4{HALF}});
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        wait_done("upd2");
        check_para("upd2", {4{ONE}});
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        wait_done("upd3");
        check_para("upd3", {4{THIRD}});
        check("busy_after_commit", 64'(busy), 64'd0);
        check("done_count_3", 64'(n_done - base), 64'd3);
        do_reset();
        base = n_done;
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        issue(HALF, NEG1, {4{NEG2}}, 1'b1, 1'b0);
        wait_done("overrun");
        repeat (40) @(negedge clk);
        check("overrun_flag", 64'(overrun), 64'd1);
        check_para("overrun", {4{HALF}});
        check("overrun_done_count", 64'(n_done - base), 64'd1);
        do_reset();
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        wait_done("pre_abort");
        base = n_done;
        issue(HALF, ONE, {4{ONE}}, 1'b1, 1'b1);
        begin
            int t = 0;
            while (!(dut.state == TAP_ADD && dut.tap == 2'd2) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL abort_wait: TAP_ADD tap 2 not reached");
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        for (int k = 0; k < 4; k++) coef[k] = 0.0;
        check_para("abort", {4{64'h0}});
        check("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done - base), 64'd0);
        #1;
        issue(HALF, ONE, {4{ONE}}, 1'b0, 1'b0);
        check("disabled_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        check("disabled_busy_later", 64'(busy), 64'd0);
        check_para("disabled", {4{64'h0}});
        check("disabled_no_done", 64'(n_done - base), 64'd0);
        #1;
        issue(HALF, ONE, {ONE, ONE, NEG2, ONE}, 1'b1, 1'b1);
        wait_done("neg_lag");
        check_para("neg_lag", {HALF, HALF, NEG1, HALF});
        do_reset();
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 4; k++) l[k] = rval(128, 64);
            en = $urandom_range(0, 4) != 0;
            issue(rval(64, 256), rval(128, 64), l, en, en);
            if (en) wait_done("rand");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (50) @(negedge clk);
        check("rand_overrun", 64'(overrun), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
